// File: rtl/serial_lane_pkg.sv
// Shared constants and types for the serial lane scheduler: word layout, idle word, FSM states.
// Combinational definitions only (no latency, no flow control).
package serial_lane_pkg;
  localparam int DEF_DW    = 8;
  localparam int DEF_FRAME = 8;

  localparam int VALID_BIT = DEF_DW;
  localparam int DATA_MSB  = DEF_DW - 1;

  localparam logic [DEF_DW:0] IDLE_WORD = {1'b0, 8'h00};

  typedef enum logic {SYNC, RUN} state_t;
endpackage

// File: rtl/serial_lane_scheduler_rr_arbiter.sv
// Masked-priority search of N requests starting at ptr; returns one-hot grant and its index.
// Purely combinational (zero latency); never stalls, req_any low means nothing to grant.
module rr_arbiter #(
  parameter int N  = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] gnt_idx,
  output logic          req_any
);
  logic [IW-1:0] idx;

  always_comb begin
    idx     = '0;
    gnt     = '0;
    gnt_idx = '0;
    req_any = 1'b0;
    for (int k = 0; k < N; k++) begin
      idx = IW'((int'(ptr) + k) % N);
      if (!req_any && req[idx]) begin
        req_any = 1'b1;
        gnt_idx = idx;
      end
    end
    if (req_any) gnt[gnt_idx] = 1'b1;
  end
endmodule

// File: rtl/serial_lane_scheduler.sv
// Shares one serializer lane among NREQ FIFOs, one word per FRAME-cycle slot; outputs registered, change at decision edges only.
// Sync period and pause send idle words; LANE_STRICT_PRIO_EN selects fixed priority instead of round-robin.
module serial_lane_scheduler
  import serial_lane_pkg::*;
#(
  parameter int NREQ        = 4,
  parameter int DW          = DEF_DW,
  parameter int FRAME       = DEF_FRAME,
  parameter int SYNC_FRAMES = 4
) (
  input  logic                    clk8f,
  input  logic                    reset,
  input  logic [NREQ-1:0]         fifo_empty,
  input  logic [NREQ*DW-1:0]      fifo_data,
  input  logic                    pause,
  output logic [NREQ-1:0]         fifo_pop,
  output logic [DW:0]             paralelo_out,
  output logic [$clog2(NREQ)-1:0] grant_id,
  output logic                    frame_start,
  output logic                    sync_done
);
  localparam int IW = $clog2(NREQ);
  localparam int FW = $clog2(FRAME);
  localparam int SW = $clog2(SYNC_FRAMES + 1);
  localparam logic [DW:0] IDLE = (DW+1)'(IDLE_WORD);

  state_t          state, state_nxt;
  logic [FW-1:0]   fcnt, fcnt_nxt;
  logic [SW-1:0]   sync_cnt, sync_cnt_nxt;
  logic            decision;
  logic [DW:0]     word_nxt;
  logic [NREQ-1:0] pop_nxt;
  logic [IW-1:0]   gid_nxt;
  logic            sdone_nxt;
  logic [IW-1:0]   arb_ptr;
  logic [NREQ-1:0] gnt;
  logic [IW-1:0]   gnt_idx;
  logic            req_any;

`ifdef LANE_STRICT_PRIO_EN
  assign arb_ptr = '0;
`else
  logic [IW-1:0] rr_ptr, rr_ptr_nxt;
  assign arb_ptr = rr_ptr;
`endif

  rr_arbiter #(.N(NREQ), .IW(IW)) u_arb (
    .req     (~fifo_empty),
    .ptr     (arb_ptr),
    .gnt     (gnt),
    .gnt_idx (gnt_idx),
    .req_any (req_any)
  );

  always_comb begin
    decision     = (fcnt == FW'(FRAME - 1));
    fcnt_nxt     = decision ? '0 : fcnt + FW'(1);
    state_nxt    = state;
    sync_cnt_nxt = sync_cnt;
    word_nxt     = paralelo_out;
    pop_nxt      = '0;
    gid_nxt      = grant_id;
    sdone_nxt    = sync_done;
`ifndef LANE_STRICT_PRIO_EN
    rr_ptr_nxt   = rr_ptr;
`endif
    if (decision) begin
      case (state)
        SYNC: begin
          word_nxt     = IDLE;
          sync_cnt_nxt = sync_cnt + SW'(1);
          if (sync_cnt == SW'(SYNC_FRAMES - 1)) begin
            state_nxt = RUN;
            sdone_nxt = 1'b1;
          end
        end
        RUN: begin
          // Pause or nothing to send: idle slot, arbitration state untouched.
          if (pause || !req_any) begin
            word_nxt = IDLE;
          end else begin
            word_nxt = {1'b1, fifo_data[gnt_idx*DW +: DW]};
            pop_nxt  = gnt;
            gid_nxt  = gnt_idx;
`ifndef LANE_STRICT_PRIO_EN
            rr_ptr_nxt = (gnt_idx == IW'(NREQ - 1)) ? '0 : gnt_idx + IW'(1);
`endif
          end
        end
        default: state_nxt = SYNC;
      endcase
    end
  end

  always_ff @(posedge clk8f) begin
    if (reset) begin
      fcnt         <= FW'(FRAME - 1);
      state        <= SYNC;
      sync_cnt     <= '0;
      paralelo_out <= '0;
      fifo_pop     <= '0;
      grant_id     <= '0;
      frame_start  <= 1'b0;
      sync_done    <= 1'b0;
`ifndef LANE_STRICT_PRIO_EN
      rr_ptr       <= '0;
`endif
    end else begin
      fcnt         <= fcnt_nxt;
      state        <= state_nxt;
      sync_cnt     <= sync_cnt_nxt;
      paralelo_out <= word_nxt;
      fifo_pop     <= pop_nxt;
      grant_id     <= gid_nxt;
      frame_start  <= decision;
      sync_done    <= sdone_nxt;
`ifndef LANE_STRICT_PRIO_EN
      rr_ptr       <= rr_ptr_nxt;
`endif
    end
  end
endmodule

// File: tb/tb_serial_lane_scheduler.sv
// Directed bench for serial_lane_scheduler: sync period, round-robin/strict grants, pause, mid-frame toggles, mid-frame reset.
module tb_serial_lane_scheduler;
  logic        clk8f = 1'b0;
  logic        reset;
  logic [3:0]  fifo_empty;
  logic [31:0] fifo_data;
  logic        pause;
  logic [3:0]  fifo_pop;
  logic [8:0]  paralelo_out;
  logic [1:0]  grant_id;
  logic        frame_start;
  logic        sync_done;

  int checks = 0;
  int passed = 0;

`ifdef LANE_STRICT_PRIO_EN
  localparam bit STRICT = 1'b1;
`else
  localparam bit STRICT = 1'b0;
`endif

  always #5 clk8f = ~clk8f;

  serial_lane_scheduler #(.NREQ(4), .DW(8), .FRAME(8), .SYNC_FRAMES(4)) dut (
    .clk8f        (clk8f),
    .reset        (reset),
    .fifo_empty   (fifo_empty),
    .fifo_data    (fifo_data),
    .pause        (pause),
    .fifo_pop     (fifo_pop),
    .paralelo_out (paralelo_out),
    .grant_id     (grant_id),
    .frame_start  (frame_start),
    .sync_done    (sync_done)
  );

  task automatic step();
    @(posedge clk8f);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Entered just after a decision edge; leaves at fcnt==7, one edge before the next decision.
  task automatic frame_check(input string tag, input logic [8:0] word, input logic [3:0] pop,
                             input logic [1:0] gid, input bit toggle);
    int bad;
    logic       sv_pause;
    logic [3:0] sv_empty;
    bad = 0;
    chk({tag, "_word"}, {23'd0, paralelo_out}, {23'd0, word});
    chk({tag, "_pop"}, {28'd0, fifo_pop}, {28'd0, pop});
    chk({tag, "_gid"}, {30'd0, grant_id}, {30'd0, gid});
    chk({tag, "_fstart"}, {31'd0, frame_start}, 32'd1);
    sv_pause = pause;
    sv_empty = fifo_empty;
    for (int j = 1; j <= 7; j++) begin
      step();
      if (paralelo_out !== word || fifo_pop !== 4'b0 || frame_start !== 1'b0 || grant_id !== gid)
        bad++;
      if (toggle && j == 3) begin
        pause      = 1'b1;
        fifo_empty = 4'b1111;
      end
      if (toggle && j == 5) begin
        pause      = sv_pause;
        fifo_empty = sv_empty;
      end
    end
    chk({tag, "_hold"}, bad, 32'd0);
  endtask

  // Entered with reset just released; covers 32 cycles (4 sync frames), leaves at fcnt==7.
  task automatic sync_phase(input string tag);
    int words_nz, pops, fstarts, sd_at;
    words_nz = 0; pops = 0; fstarts = 0; sd_at = 0;
    for (int j = 1; j <= 32; j++) begin
      step();
      if (paralelo_out !== 9'h000) words_nz++;
      if (fifo_pop !== 4'b0) pops++;
      if (frame_start === 1'b1) fstarts++;
      if (sync_done === 1'b1 && sd_at == 0) sd_at = j;
    end
    chk({tag, "_idle_words"}, words_nz, 32'd0);
    chk({tag, "_no_pops"}, pops, 32'd0);
    chk({tag, "_frame_starts"}, fstarts, 32'd4);
    chk({tag, "_sync_done_edge"}, sd_at, 32'd25);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0] g;
    reset      = 1'b1;
    pause      = 1'b0;
    fifo_empty = 4'b0000;
    fifo_data  = {8'hD3, 8'hD2, 8'hD1, 8'hD0};
    repeat (3) step();
    chk("rst_word", {23'd0, paralelo_out}, 32'd0);
    chk("rst_pop", {28'd0, fifo_pop}, 32'd0);
    chk("rst_gid", {30'd0, grant_id}, 32'd0);
    chk("rst_fstart", {31'd0, frame_start}, 32'd0);
    chk("rst_sdone", {31'd0, sync_done}, 32'd0);

    reset = 1'b0;
    sync_phase("sync1");
    step();

    // Eight frames with every FIFO holding data.
    for (int f = 0; f < 8; f++) begin
      g = STRICT ? 2'd0 : 2'(f % 4);
      frame_check("rr", 9'h100 | {1'b0, 8'hD0 + {6'd0, g}}, 4'b0001 << g, g, 1'b0);
      step();
    end

    // Only FIFO2 has data; its head was already presented at the edge above, so redo that edge.
    // (Previous loop stepped into a decision edge with all FIFOs full: check and consume it.)
    g = STRICT ? 2'd0 : 2'd0;
    frame_check("rr_wrap", 9'h1D0, 4'b0001, g, 1'b0);
    fifo_empty = 4'b1011;
    fifo_data[23:16] = 8'hA5;
    step();
    frame_check("only2", 9'h1A5, 4'b0100, 2'd2, 1'b0);

    fifo_empty = 4'b1101;
    pause = 1'b1;
    step();
    frame_check("pause", 9'h000, 4'b0000, 2'd2, 1'b0);

    pause = 1'b0;
    step();
    frame_check("after_pause", 9'h1D1, 4'b0010, 2'd1, 1'b0);

    fifo_empty = 4'b0000;
    fifo_data[23:16] = 8'hD2;
    step();
    g = STRICT ? 2'd0 : 2'd2;
    frame_check("midtoggle", 9'h100 | {1'b0, 8'hD0 + {6'd0, g}}, 4'b0001 << g, g, 1'b1);

    step();
    g = STRICT ? 2'd0 : 2'd3;
    chk("pre_rst_word", {23'd0, paralelo_out}, {23'd0, 9'h100 | {1'b0, 8'hD0 + {6'd0, g}}});
    chk("pre_rst_pop", {28'd0, fifo_pop}, {28'd0, 4'b0001 << g});
    repeat (5) step();
    reset = 1'b1;
    step();
    chk("midrst_word", {23'd0, paralelo_out}, 32'd0);
    chk("midrst_pop", {28'd0, fifo_pop}, 32'd0);
    chk("midrst_sdone", {31'd0, sync_done}, 32'd0);
    step();
    reset = 1'b0;
    sync_phase("sync2");
    step();
    frame_check("resume", 9'h1D0, 4'b0001, 2'd0, 1'b0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule

// File: doc/serial_lane_scheduler.md
Name: serial_lane_scheduler

Overview:
- Frame-level scheduler that shares one parallel-to-serial lane among NREQ show-ahead FIFOs.
- Once per FRAME-cycle word slot it presents the serializer's 9-bit {valid,data} input word and pops the granted FIFO.
- With valid=0 the serializer emits its idle/comma pattern. The scheduler therefore also sequences the post-reset link sync period and backpressure pauses.
- Sits between the lane FIFOs and the serializer, in the clk8f domain.

Parameters:
- NREQ, 4, number of requesting FIFOs (2..8).
- DW, 8, data width per word.
- FRAME, 8, clk8f cycles per word slot; must equal DW.
- SYNC_FRAMES, 4, idle (valid=0) frames forced after reset before data may be sent.

Ports:
- clk8f  in  1  only clock; one serial bit per cycle.
- reset  in  1  synchronous, active-high reset.
- fifo_empty  in  NREQ  per-requester empty flag.
- fifo_data  in  NREQ*DW  per-requester head word; requester i at bits [i*DW+DW-1 : i*DW]; valid whenever !fifo_empty[i].
- pause  in  1  link backpressure from the far end; high means send idle.
- fifo_pop  out  NREQ  one-hot pop, registered.
- paralelo_out  out  DW+1  to serializer: bit DW = valid, [DW-1:0] = data; registered.
- grant_id  out  $clog2(NREQ)  index of the requester owning the current frame; registered.
- frame_start  out  1  high during cycle fcnt==0; registered.
- sync_done  out  1  high once the sync period has ended; registered.

Behaviour:
- Reset is sampled on posedge clk8f only. While reset=1:
  - fcnt=FRAME-1, state=SYNC, sync_cnt=0, rr_ptr=0.
  - paralelo_out=0, fifo_pop=0, grant_id=0, frame_start=0, sync_done=0.
- Frame counter fcnt (width $clog2(FRAME)):
  - Free-running: increments each cycle, wraps FRAME-1 -> 0.
  - Decision edge = the posedge where fcnt==FRAME-1. Because fcnt resets to FRAME-1, the first edge after reset release is a decision edge.
- paralelo_out, grant_id and fifo_pop change only at decision edges. paralelo_out is stable for the full FRAME cycles of its slot.
- fifo_pop[g] is high for exactly one cycle, the fcnt==0 cycle of the slot carrying that FIFO's word. The FIFO advances on the following edge. Every other cycle fifo_pop=0.
- States:
  - SYNC:
    - Every decision edge drives paralelo_out={1'b0, DW'h00} and sync_cnt++.
    - On the edge where sync_cnt reaches SYNC_FRAMES: state->RUN and sync_done<=1.
    - No pops in SYNC, even if FIFOs are non-empty.
  - RUN, at each decision edge:
    - If pause=1 or all fifo_empty=1: paralelo_out<=0, no pop, rr_ptr and grant_id unchanged.
    - Else: g = first non-empty index searching rr_ptr, rr_ptr+1, ... mod NREQ. Then paralelo_out<={1'b1, fifo_data[g]}, fifo_pop[g]<=1, grant_id<=g, rr_ptr<=(g+1) mod NREQ.
- fifo_empty and pause are sampled only at decision edges; changes mid-frame have no effect.
- Reset asserted mid-frame: the current word is abandoned and the slot is truncated. The serializer sees valid=0 from the next cycle. SYNC restarts from sync_cnt=0.
- frame_start: registered copy of (next fcnt==0); high for one cycle per frame, starting with the first cycle after reset release.

Optional Feature:
- LANE_STRICT_PRIO_EN defined: RUN arbitration is fixed priority, the lowest non-empty index always wins, and rr_ptr is not implemented.
- Undefined: round-robin as specified above.
- All other behaviour is identical.

Decomposition:
- Shared package serial_lane_pkg:
  - FRAME and DW defaults.
  - Word field positions: VALID_BIT=DW, DATA_MSB=DW-1.
  - IDLE_WORD = {1'b0, DW'h00}.
  - State enum {SYNC, RUN}.
- One natural sub-module: rr_arbiter (combinational masked-priority search of NREQ requests from a pointer, returning a one-hot grant and its index). The strict-priority variant is an rr_arbiter with the pointer tied to 0.

Test Plan:
- Reset 3 cycles, all FIFOs non-empty -> 4 frames (32 cycles) of paralelo_out=9'h000 with no pops. sync_done rises at the 4th decision edge. The first valid word appears on the 5th frame.
- RUN, only FIFO2 non-empty, head 8'hA5 -> paralelo_out=9'h1A5 held 8 cycles, grant_id=2, fifo_pop=4'b0100 for one cycle at frame_start.
- RUN, all 4 FIFOs non-empty for 8 frames -> grant order 0,1,2,3,0,1,2,3 with exactly one pop per frame. With LANE_STRICT_PRIO_EN defined -> grant 0 every frame.
- pause=1 sampled at a decision edge while FIFO1 is non-empty -> that frame carries 9'h000 with no pop. After pause falls, the next frame grants FIFO1 and the round-robin pointer is unchanged.
- pause and fifo_empty toggled mid-frame (fcnt=3) -> paralelo_out unchanged until the next decision edge.
- reset asserted at fcnt=5 of a valid frame -> next cycle paralelo_out=0, fifo_pop=0. After release, 4 sync frames repeat before data resumes.
